// File: rtl/click_pkg.sv
// Shared types and defaults for the multi-click button decoder.
package click_pkg;

   typedef enum logic {
      IDLE     = 1'b0,
      COUNTING = 1'b1
   } click_state_e;

   localparam int unsigned DEFAULT_WINDOW     = 25000000;
   localparam int unsigned DEFAULT_MAX_CLICKS = 3;
   localparam int unsigned CNT_W              = 2;

endpackage

// File: rtl/window_timer.sv
// Saturating gap timer: counts idle cycles between presses of one sequence.
module window_timer #(
   parameter int unsigned WINDOW = 25000000
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clear,
   input  logic enable,
   output logic expired
);

   localparam int unsigned TW = $clog2(WINDOW);
   localparam logic [TW-1:0] LAST = TW'(WINDOW - 1);

   logic [TW-1:0] cnt_q;
   logic [TW-1:0] cnt_d;

   assign expired = (cnt_q == LAST);

   // Holds at LAST rather than wrapping; the FSM closes on that value.
   always_comb begin
      cnt_d = cnt_q;
      if (clear) begin
         cnt_d = '0;
      end else if (enable && !expired) begin
         cnt_d = cnt_q + TW'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/click_decoder.sv
// Groups debounced press pulses into single/double/triple click events.
module click_decoder
   import click_pkg::*;
#(
   parameter int unsigned WINDOW     = DEFAULT_WINDOW,
   parameter int unsigned MAX_CLICKS = DEFAULT_MAX_CLICKS
) (
   input  logic             CLK,
   input  logic             RST_N,
   input  logic             Press,
   output logic             Event,
   output logic [CNT_W-1:0] Count,
   output logic             Busy
);

   localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_CLICKS);

   click_state_e     state_q, state_d;
   logic [CNT_W-1:0] presses_q, presses_d;
   logic             event_q, event_d;
   logic [CNT_W-1:0] count_q, count_d;

   logic             close_s;
   logic [CNT_W-1:0] fin_cnt;
   logic [CNT_W-1:0] presses_inc;
   logic             tmr_clear;
   logic             tmr_en;
   logic             tmr_expired;

   assign presses_inc = presses_q + CNT_W'(1);

   window_timer #(
      .WINDOW(WINDOW)
   ) u_timer (
      .clk    (CLK),
      .rst_n  (RST_N),
      .clear  (tmr_clear),
      .enable (tmr_en),
      .expired(tmr_expired)
   );

   always_comb begin
      state_d   = state_q;
      presses_d = presses_q;
      close_s   = 1'b0;
      fin_cnt   = presses_q;
      tmr_clear = 1'b0;
      tmr_en    = 1'b0;
      unique case (state_q)
         IDLE: begin
            tmr_clear = 1'b1;
            if (Press) begin
               if (MAX_CNT == CNT_W'(1)) begin
                  close_s = 1'b1;
                  fin_cnt = CNT_W'(1);
               end else begin
                  state_d   = COUNTING;
                  presses_d = CNT_W'(1);
               end
            end
         end
         COUNTING: begin
            // A press on the expiry cycle wins over the timeout.
            if (Press) begin
               tmr_clear = 1'b1;
               if (presses_inc == MAX_CNT) begin
                  close_s   = 1'b1;
                  fin_cnt   = presses_inc;
                  state_d   = IDLE;
                  presses_d = '0;
               end else begin
                  presses_d = presses_inc;
               end
            end else if (tmr_expired) begin
               close_s   = 1'b1;
               fin_cnt   = presses_q;
               state_d   = IDLE;
               presses_d = '0;
               tmr_clear = 1'b1;
            end else begin
               tmr_en = 1'b1;
            end
         end
      endcase
      event_d = close_s;
      count_d = close_s ? fin_cnt : '0;
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state_q   <= IDLE;
         presses_q <= '0;
         event_q   <= 1'b0;
         count_q   <= '0;
      end else begin
         state_q   <= state_d;
         presses_q <= presses_d;
         event_q   <= event_d;
         count_q   <= count_d;
      end
   end

   assign Event = event_q;
   assign Count = count_q;
   assign Busy  = (state_q == COUNTING);

endmodule

// File: tb/tb_click_decoder.sv
// Bench for click_decoder: fixed vector table, corner sequences, random vs model.
module tb_click_decoder;

   localparam int WIN_A = 8;
   localparam int MAX_A = 3;
   localparam int WIN_B = 5;
   localparam int MAX_B = 2;

   logic       clk   = 1'b0;
   logic       rst_n = 1'b0;
   logic       press = 1'b0;
   logic       ev_a, busy_a, ev_b, busy_b;
   logic [1:0] cnt_a, cnt_b;

   int checks = 0;
   int fails  = 0;
   int cyc    = 0;

   always #5 clk = ~clk;

   click_decoder #(.WINDOW(WIN_A), .MAX_CLICKS(MAX_A)) dut_a (
      .CLK  (clk),
      .RST_N(rst_n),
      .Press(press),
      .Event(ev_a),
      .Count(cnt_a),
      .Busy (busy_a)
   );

   click_decoder #(.WINDOW(WIN_B), .MAX_CLICKS(MAX_B)) dut_b (
      .CLK  (clk),
      .RST_N(rst_n),
      .Press(press),
      .Event(ev_b),
      .Count(cnt_b),
      .Busy (busy_b)
   );

   typedef struct {
      logic       p;
      logic       ev;
      logic [1:0] c;
      logic       b;
   } vec_t;

   vec_t tbl[$];

   // Reference model: timestamps of presses, not a cycle timer.
   bit m_open[2];
   int m_n[2];
   int m_last[2];

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)",
                  name, act, exp, cyc);
      end
   endtask

   task automatic tick(input logic p);
      @(negedge clk);
      press = p;
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic add(input logic p, input logic ev, input logic [1:0] c,
                      input logic b, input int n);
      vec_t v;
      v.p  = p;
      v.ev = ev;
      v.c  = c;
      v.b  = b;
      repeat (n) tbl.push_back(v);
   endtask

   task automatic model_step(input int k, input bit p, input int t,
                             input int win, input int mx,
                             output bit ev, output int c, output bit b);
      ev = 1'b0;
      c  = 0;
      if (p) begin
         if (!m_open[k]) begin
            m_open[k] = 1'b1;
            m_n[k]    = 0;
         end
         m_n[k]++;
         m_last[k] = t;
         if (m_n[k] == mx) begin
            ev        = 1'b1;
            c         = m_n[k];
            m_open[k] = 1'b0;
         end
      end else if (m_open[k] && (t - m_last[k]) == win) begin
         ev        = 1'b1;
         c         = m_n[k];
         m_open[k] = 1'b0;
      end
      b = m_open[k];
   endtask

   task automatic chk_out(input string tag, input logic ev, input logic [1:0] c,
                          input logic b);
      chk({tag, "_event"}, 32'(ev_a),   32'(ev));
      chk({tag, "_count"}, 32'(cnt_a),  32'(c));
      chk({tag, "_busy"},  32'(busy_a), 32'(b));
   endtask

   initial begin
      bit seen;
      bit eva, evb, ba, bb;
      int ca, cb;
      bit p;
      int dens;

      // single press, timeout
      add(1, 0, 0, 1, 1);
      add(0, 0, 0, 1, 7);
      add(0, 1, 1, 0, 1);
      add(0, 0, 0, 0, 1);
      // max clicks 3 apart, then a press in the Event cycle
      add(1, 0, 0, 1, 1);
      add(0, 0, 0, 1, 2);
      add(1, 0, 0, 1, 1);
      add(0, 0, 0, 1, 2);
      add(1, 1, 3, 0, 1);
      add(1, 0, 0, 1, 1);
      add(0, 0, 0, 1, 7);
      add(0, 1, 1, 0, 1);
      add(0, 0, 0, 0, 1);
      // press exactly on the expiry cycle
      add(1, 0, 0, 1, 1);
      add(0, 0, 0, 1, 7);
      add(1, 0, 0, 1, 1);
      add(0, 0, 0, 1, 7);
      add(0, 1, 2, 0, 1);
      // double press 5 apart
      add(1, 0, 0, 1, 1);
      add(0, 0, 0, 1, 4);
      add(1, 0, 0, 1, 1);
      add(0, 0, 0, 1, 7);
      add(0, 1, 2, 0, 1);
      add(0, 0, 0, 0, 1);

      // reset state, with Press high to show it is ignored
      press = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      chk_out("reset", 0, 0, 0);
      @(negedge clk);
      press = 1'b0;
      rst_n = 1'b1;

      foreach (tbl[i]) begin
         tick(tbl[i].p);
         chk_out($sformatf("vec%0d", i), tbl[i].ev, tbl[i].c, tbl[i].b);
      end

      // reset mid-sequence discards it
      tick(1);
      tick(0);
      tick(1);
      tick(0);
      chk("pre_reset_busy", 32'(busy_a), 32'd1);
      #2;
      rst_n = 1'b0;
      #1;
      chk_out("async_reset", 0, 0, 0);
      @(negedge clk);
      press = 1'b1;
      @(posedge clk);
      #1;
      chk("press_in_reset_busy", 32'(busy_a), 32'd0);
      @(negedge clk);
      press = 1'b0;
      rst_n = 1'b1;
      seen  = 1'b0;
      repeat (12) begin
         tick(0);
         seen |= ev_a;
      end
      chk("no_event_after_reset", 32'(seen), 32'd0);

      // reset while Event is high
      tick(1);
      tick(0);
      tick(1);
      tick(0);
      tick(1);
      chk("max_event", 32'(ev_a), 32'd1);
      chk("max_count", 32'(cnt_a), 32'd3);
      #2;
      rst_n = 1'b0;
      #1;
      chk_out("reset_on_event", 0, 0, 0);

      // first edge after release samples Press
      @(negedge clk);
      press = 1'b1;
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      cyc++;
      chk("first_edge_busy", 32'(busy_a), 32'd1);
      repeat (7) tick(0);
      chk_out("rel_pre_timeout", 0, 0, 1);
      tick(0);
      chk_out("rel_timeout", 1, 1, 0);
      // back-to-back: press while Event high
      tick(1);
      chk_out("b2b_open", 0, 0, 1);
      repeat (7) tick(0);
      chk_out("b2b_wait", 0, 0, 1);
      tick(0);
      chk_out("b2b_close", 1, 1, 0);

      // randomized run on both instances against the model
      @(negedge clk);
      press = 1'b0;
      rst_n = 1'b0;
      @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      for (int k = 0; k < 2; k++) begin
         m_open[k] = 1'b0;
         m_n[k]    = 0;
         m_last[k] = 0;
      end
      for (int t = 0; t < 3000; t++) begin
         dens = (t / 500) % 3;
         case (dens)
            0:       p = ($urandom_range(0, 2) == 0);
            1:       p = ($urandom_range(0, 6) == 0);
            default: p = ($urandom_range(0, 12) == 0);
         endcase
         tick(p);
         model_step(0, p, t, WIN_A, MAX_A, eva, ca, ba);
         model_step(1, p, t, WIN_B, MAX_B, evb, cb, bb);
         chk("rnd_a_event", 32'(ev_a),   32'(eva));
         chk("rnd_a_count", 32'(cnt_a),  32'(ca));
         chk("rnd_a_busy",  32'(busy_a), 32'(ba));
         chk("rnd_b_event", 32'(ev_b),   32'(evb));
         chk("rnd_b_count", 32'(cnt_b),  32'(cb));
         chk("rnd_b_busy",  32'(busy_b), 32'(bb));
      end

      $display("End of test - %0d assertions evaluated, %0d failures",
               checks, fails);
      $finish;
   end

endmodule

// File: doc/click_decoder.md
CLICK_DECODER -- requirements
Module: click_decoder

Interface
REQ-001 Parameter WINDOW, default 25000000, is the maximum gap in CLK cycles between consecutive presses of one sequence (250 ms at 100 MHz); legal range 2..2^26.
REQ-002 Parameter MAX_CLICKS, default 3, is the press count that closes a sequence immediately; legal range 1..3.
REQ-003 CLK  input  1  single system clock; all state changes on its rising edge.
REQ-004 RST_N  input  1  reset, asynchronous assert, active-low.
REQ-005 Press  input  1  debounced press pulse from ButtonFilter, high for exactly one CLK cycle per press.
REQ-006 Event  output  1  one-cycle pulse marking a completed click sequence.
REQ-007 Count  output  2  presses in the completed sequence (1..MAX_CLICKS); valid only while Event=1.
REQ-008 Busy  output  1  high while a sequence is open (state COUNTING).

Function
REQ-009 The FSM SHALL have exactly two states, IDLE and COUNTING; the reset state is IDLE.
REQ-010 In IDLE, Press=1 SHALL set the press counter to 1 and the gap timer to 0, and move to COUNTING (or close immediately per REQ-013 if MAX_CLICKS=1).
REQ-011 In COUNTING, each cycle without Press SHALL increment the gap timer by 1.
REQ-012 In COUNTING, Press=1 SHALL increment the press counter, clear the gap timer to 0, and stay in COUNTING unless REQ-013 applies.
REQ-013 A Press that brings the press counter to MAX_CLICKS SHALL close the sequence: the FSM returns to IDLE and the timer is not restarted.
REQ-014 In COUNTING, gap timer == WINDOW-1 with Press=0 SHALL close the sequence (timeout) and return to IDLE.
REQ-015 If Press=1 and timer == WINDOW-1 in the same cycle, the press SHALL win: it is counted and the timer restarts (REQ-012/013).
REQ-016 On every close, Event SHALL be 1 and Count SHALL hold the final press count in the cycle immediately after the closing edge; latency is exactly one cycle.
REQ-017 Event SHALL be 1 for exactly one cycle per close. Count SHALL read 0 whenever Event=0.
REQ-018 A Press arriving in the cycle Event is high, with the FSM in IDLE, SHALL open a new sequence normally; no press is lost or merged.
REQ-019 The press counter SHALL never exceed MAX_CLICKS and the gap timer SHALL never exceed WINDOW-1 (no wrap-around).
REQ-020 Busy SHALL equal (state == COUNTING), driven from the state register with no combinational path from Press.

Reset
REQ-021 While RST_N=0, the FSM SHALL be in IDLE, the press counter and gap timer SHALL be 0, and Event=0, Count=0, Busy=0.
REQ-022 Reset asserted mid-sequence SHALL discard the open sequence with no Event, either during reset or after it.
REQ-023 Press SHALL be ignored while RST_N=0; the first rising CLK edge after release SHALL sample Press normally.

Structure
REQ-024 The state encoding (IDLE=0, COUNTING=1) and the default WINDOW and MAX_CLICKS values SHALL live in shared package click_pkg.
REQ-025 The gap timer SHALL be the sub-module window_timer, with ports clear, enable and expired, and a width of $clog2(WINDOW) bits.
REQ-026 All outputs SHALL be registered.

Verification (WINDOW=8, MAX_CLICKS=3)
REQ-027 Single press: one Press, then idle -> Busy high for 8 cycles; Event=1, Count=1 one cycle after the timeout edge; Busy=0 afterwards.
REQ-028 Double press: presses 5 cycles apart -> one Event with Count=2, 8 cycles after the second press's timer restart plus one.
REQ-029 Max clicks: three presses 3 cycles apart -> Event with Count=3 one cycle after the third press, with no timeout wait; a fourth press 1 cycle later opens a new sequence that closes with Count=1.
REQ-030 Tie: a press exactly on the timer==7 cycle -> counted, no Event that cycle, and the timer restarts at 0.
REQ-031 Reset: RST_N low after 2 presses -> Count, Event and Busy go to 0 asynchronously; no Event ever follows for that sequence.
REQ-032 Back-to-back: a Press in the same cycle as Event -> a second, independent Event with Count=1, 9 cycles later.
